ps2_frame_rx: RTL
=================

# ps2_frame_rx

PS/2 device-to-host frame receiver running in the system clock domain. Synchronises and filters the raw keyboard clock/data pins, deserialises 11-bit frames, checks start/parity/stop, folds the 0xF0 (break) and 0xE0 (extended) prefixes into flags, and presents one scancode per key event on a valid/ready handshake. Sits directly upstream of the keyboard command decoder, which consumes `code`/`is_break`.

## Interface
- SYNC_STAGES, 2, flip-flop stages on each PS/2 pin (min 2)
- FILTER_LEN, 4, consecutive identical synchronised samples required before the filtered ps2_clk level changes
- TIMEOUT_CYC, 50000, system cycles without a filtered ps2_clk falling edge before a partial frame is abandoned

- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- ps2_clk  in  1  raw keyboard clock pin, asynchronous
- ps2_data  in  1  raw keyboard data pin, asynchronous
- code  out  8  received scancode, prefixes stripped
- is_break  out  1  code was preceded by 0xF0
- is_ext  out  1  code was preceded by 0xE0
- code_valid  out  1  code/is_break/is_ext valid; held until accepted
- code_ready  in  1  consumer accepts on code_valid && code_ready
- frame_err  out  1  one-cycle pulse: bad start, parity, stop or timeout
- overrun  out  1  one-cycle pulse: completed code dropped because output slot was full

## Operation
- Reset: all outputs 0, FSM IDLE, bit counter 0, prefix flags clear, timeout counter 0.
- Both pins pass through SYNC_STAGES flops; ps2_clk additionally through the FILTER_LEN glitch filter (filtered level resets to 1). A falling edge of the filtered clock is a one-cycle `fall` strobe; ps2_data (synchronised) is sampled in that same cycle.
- FSM (advances only on `fall`, except timeout):
  - IDLE: sample 0 -> DATA, bit counter 0; sample 1 -> stay IDLE, frame_err pulse.
  - DATA: shift sample in LSB first; after bit 7 -> PARITY.
  - PARITY: store sample -> STOP.
  - STOP: sample must be 1 and XOR(data[7:0], parity) must be 1 (odd parity); otherwise frame_err pulse. -> IDLE either way.
- Good frame: byte 0xF0 sets break_pend; 0xE0 sets ext_pend; neither is emitted. Any other byte is emitted with is_break=break_pend, is_ext=ext_pend; both pends then clear.
- Any frame_err (incl. timeout) clears both pends.
- Output slot: one entry. Emit when slot empty or being accepted this cycle -> load, code_valid=1. Emit while code_valid && !code_ready -> new code dropped, held code unchanged, overrun pulse; pends still clear.
- Timeout: counter clears on every `fall` and in IDLE; in DATA/PARITY/STOP, reaching TIMEOUT_CYC-1 -> IDLE, frame_err pulse, counter 0.
- Outputs change only on posedge clk; code stable while code_valid && !code_ready.

## Timing
- `fall` occurs SYNC_STAGES+FILTER_LEN cycles (±1) after the pin edge.
- code_valid rises the cycle after the `fall` that samples the stop bit (registered).
- frame_err/overrun asserted exactly one cycle per event.
- code_valid deasserts the cycle after acceptance unless a new code loads the same cycle (then stays 1 with new code).
- rst_n low mid-frame: next cycle fully reset; partial frame discarded, no error pulse.

## Configuration
- PS2_RX_PARITY_EN defined: parity checked as above, failure -> frame_err, byte discarded.
- Undefined: parity bit sampled and ignored; only start, stop and timeout produce frame_err.

## Structure
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), SC_BREAK = 8'hF0, SC_EXT = 8'hE0, DATA_BITS = 8.
- Sub-module ps2_line_filter: synchroniser + FILTER_LEN glitch filter + falling-edge strobe for ps2_clk; ps2_data uses a plain synchroniser from the same module with filtering disabled via parameter.

## Test plan
- Frame 0x1C, odd parity, code_ready=1 -> code_valid one cycle, code=0x1C, is_break=0, is_ext=0.
- Frames F0,1C -> single emit code=0x1C, is_break=1; F0 alone emits nothing.
- Frames E0,F0,75 -> code=0x75, is_ext=1, is_break=1; following 0x75 -> both flags 0.
- Parity bit flipped on 0x1C (PS2_RX_PARITY_EN) -> frame_err pulse, no code_valid; same stimulus with macro undefined -> code=0x1C.
- code_ready=0, send 0x16 then 0x1E -> code held 0x16, one overrun pulse; raise ready -> accepted, code_valid drops.
- Stop after 5 data bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; then full 0x29 frame -> code=0x29; rst_n pulse mid-frame -> no output, no error.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0]  SC_BREAK  = 8'hF0;
  localparam logic [7:0]  SC_EXT    = 8'hE0;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Pin synchroniser with optional glitch filter and falling-edge strobe.
// FILTER_EN=0 gives a plain synchroniser; fall then follows the raw synchronised level.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter bit          FILTER_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (FILTER_EN) begin : g_filter
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] cnt;
    logic          lvl_q;
    logic          fall_q;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= '0;
        lvl_q  <= 1'b1;
        fall_q <= 1'b0;
      end else begin
        fall_q <= 1'b0;
        if (sync_out == lvl_q) begin
          cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
          cnt    <= '0;
          lvl_q  <= sync_out;
          fall_q <= lvl_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign level = lvl_q;
    assign fall  = fall_q;
  end else begin : g_plain
    logic prev_q;

    always_ff @(posedge clk) begin
      if (!rst_n) prev_q <= 1'b1;
      else        prev_q <= sync_out;
    end

    assign level = sync_out;
    assign fall  = prev_q & ~sync_out;
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with F0/E0 prefix folding and a one-entry output slot.
// Define PS2_RX_PARITY_EN to reject frames with bad odd parity.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_ext,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic fall;
  logic clk_level_unused;
  logic data_s;
  logic data_fall_unused;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .FILTER_EN  (1'b1)
  ) u_clk_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (ps2_clk),
    .level(clk_level_unused),
    .fall (fall)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .FILTER_EN  (1'b0)
  ) u_data_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (ps2_data),
    .level(data_s),
    .fall (data_fall_unused)
  );

  state_t        state, state_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    shreg, sh_d;
  logic          break_pend, brk_d;
  logic          ext_pend, ext_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          err_d;
  logic          emit;
  logic          parity_ok;

`ifdef PS2_RX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                        par_q <= 1'b0;
    else if (fall && state == PARITY) par_q <= data_s;
  end

  assign parity_ok = ^{shreg, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    sh_d    = shreg;
    brk_d   = break_pend;
    ext_d   = ext_pend;
    err_d   = 1'b0;
    emit    = 1'b0;
    tcnt_d  = (state == IDLE || fall) ? '0 : tcnt + 1'b1;

    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          sh_d  = {data_s, shreg[7:1]};
          bit_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (data_s && parity_ok) begin
            if (shreg == SC_BREAK)    brk_d = 1'b1;
            else if (shreg == SC_EXT) ext_d = 1'b1;
            else begin
              emit  = 1'b1;
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tcnt_d  = '0;
    end

    if (err_d) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      tcnt       <= '0;
      code       <= '0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_d;
      shreg      <= sh_d;
      break_pend <= brk_d;
      ext_pend   <= ext_d;
      tcnt       <= tcnt_d;
      frame_err  <= err_d;
      overrun    <= 1'b0;
      // A slot being accepted this cycle can take the new code directly.
      if (emit && (!code_valid || code_ready)) begin
        code       <= shreg;
        is_break   <= break_pend;
        is_ext     <= ext_pend;
        code_valid <= 1'b1;
      end else begin
        if (emit) overrun <= 1'b1;
        if (code_valid && code_ready) code_valid <= 1'b0;
      end
    end
  end

endmodule
